// File: rtl/fifo_async_lvl.sv
// fifo_async_lvl
//   Dual-clock FIFO with fill-level reporting on both sides, almost-full /
//   almost-empty thresholds and sticky overflow/underflow flags. Pointers
//   cross domains as Gray codes through SYNC_STAGES-deep flop chains. The
//   read port is show-ahead: o_rdata always presents the head word.
//
// Ports
//   i_wclk, i_wrstn      write clock, async active-low write-domain reset
//   i_rclk, i_rrstn      read clock, async active-low read-domain reset
//   i_wr, i_wdata        write request and data
//   o_wfull              registered full (exact on the write side)
//   o_walmost_full       registered wcount >= AF_THRESH
//   o_wcount             write-side level (may overstate occupancy)
//   o_woverflow          sticky: write attempted while full
//   i_rd                 read request / pop
//   o_rdata              head word, valid while !o_rempty
//   o_rempty             registered empty (exact on the read side)
//   o_ralmost_empty      registered rcount <= AE_THRESH
//   o_rcount             read-side level (may understate occupancy)
//   o_runderflow         sticky: read attempted while empty
//   i_clr_err            read-domain pulse clearing both sticky flags
module fifo_async_lvl #(
    parameter int DATA_WIDTH  = 8,
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12,
    parameter int AE_THRESH   = 2
) (
    input  logic                  i_wclk,
    input  logic                  i_wrstn,
    input  logic                  i_rclk,
    input  logic                  i_rrstn,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_wfull,
    output logic                  o_walmost_full,
    output logic [PTR_WIDTH:0]    o_wcount,
    output logic                  o_woverflow,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rempty,
    output logic                  o_ralmost_empty,
    output logic [PTR_WIDTH:0]    o_rcount,
    output logic                  o_runderflow,
    input  logic                  i_clr_err
);

    localparam int DEPTH = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] LVL_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] LVL_AF   = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] LVL_AE   = (PTR_WIDTH+1)'(AE_THRESH);

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PTR_WIDTH:0]   wbin;
    logic [PTR_WIDTH:0]   wptr;
    logic [PTR_WIDTH:0]   wbin_next;
    logic [PTR_WIDTH:0]   wgray_next;
    logic [PTR_WIDTH:0]   wsync_rbin;
    logic [PTR_WIDTH:0]   wlvl;
    logic [PTR_WIDTH:0]   wq_rptr [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] wq_clr;
    logic                 wclr_prev;
    logic                 wclr_pulse;
    logic                 wr_accept;

    // ---------------- read domain ----------------
    logic [PTR_WIDTH:0]   rbin;
    logic [PTR_WIDTH:0]   rptr;
    logic [PTR_WIDTH:0]   rbin_next;
    logic [PTR_WIDTH:0]   rgray_next;
    logic [PTR_WIDTH:0]   rsync_wbin;
    logic [PTR_WIDTH:0]   rlvl;
    logic [PTR_WIDTH:0]   rq_wptr [SYNC_STAGES];
    logic                 rclr_tgl;
    logic                 rd_accept;

    always_comb begin
        wr_accept  = i_wr && !o_wfull;
        wbin_next  = wbin + {{PTR_WIDTH{1'b0}}, wr_accept};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        wsync_rbin = gray2bin(wq_rptr[SYNC_STAGES-1]);
        // Modulo subtraction; the pointer MSB makes DEPTH distinct from 0.
        wlvl       = wbin_next - wsync_rbin;
        // Each i_clr_err flips rclr_tgl once; any change seen here is one clear.
        wclr_pulse = wq_clr[SYNC_STAGES-1] ^ wclr_prev;
    end

    always_ff @(posedge i_wclk) begin
        if (wr_accept) begin
            mem[wbin[PTR_WIDTH-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_wclk or negedge i_wrstn) begin
        if (!i_wrstn) begin
            wbin           <= '0;
            wptr           <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wq_rptr[i] <= '0;
            end
            wq_clr         <= '0;
            wclr_prev      <= 1'b0;
            o_wfull        <= 1'b0;
            o_walmost_full <= 1'b0;
            o_wcount       <= '0;
            o_woverflow    <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            wptr       <= wgray_next;
            wq_rptr[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wq_rptr[i] <= wq_rptr[i-1];
            end
            wq_clr         <= {wq_clr[SYNC_STAGES-2:0], rclr_tgl};
            wclr_prev      <= wq_clr[SYNC_STAGES-1];
            o_wcount       <= wlvl;
            o_wfull        <= (wlvl == LVL_FULL);
            o_walmost_full <= (wlvl >= LVL_AF);
            // Set has priority over a clear arriving on the same edge.
            if (i_wr && o_wfull) begin
                o_woverflow <= 1'b1;
            end else if (wclr_pulse) begin
                o_woverflow <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_accept  = i_rd && !o_rempty;
        rbin_next  = rbin + {{PTR_WIDTH{1'b0}}, rd_accept};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        rsync_wbin = gray2bin(rq_wptr[SYNC_STAGES-1]);
        rlvl       = rsync_wbin - rbin_next;
    end

    // Show-ahead: head word follows the read address combinationally.
    assign o_rdata = mem[rbin[PTR_WIDTH-1:0]];

    always_ff @(posedge i_rclk or negedge i_rrstn) begin
        if (!i_rrstn) begin
            rbin            <= '0;
            rptr            <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_wptr[i] <= '0;
            end
            rclr_tgl        <= 1'b0;
            o_rempty        <= 1'b1;
            o_ralmost_empty <= 1'b1;
            o_rcount        <= '0;
            o_runderflow    <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            rptr       <= rgray_next;
            rq_wptr[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_wptr[i] <= rq_wptr[i-1];
            end
            rclr_tgl        <= rclr_tgl ^ i_clr_err;
            o_rcount        <= rlvl;
            o_rempty        <= (rlvl == '0);
            o_ralmost_empty <= (rlvl <= LVL_AE);
            if (i_rd && o_rempty) begin
                o_runderflow <= 1'b1;
            end else if (i_clr_err) begin
                o_runderflow <= 1'b0;
            end
        end
    end

endmodule
